// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the voltmeter capture path: controller states,
// XADC/screen constants and the ADC-code-to-screen-height scaling.
package voltmeter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_DRP_REQ,
    ST_DRP_WAIT,
    ST_STORE,
    ST_FULL,
    ST_ARM
  } ctrl_state_e;

  localparam logic [6:0] XADC_VAUX6_ADDR = 7'h16;
  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;

  // 12-bit left-justified code * 15 / 128 maps full scale (4095) to 479.
  function automatic logic [8:0] scale_height(input logic [15:0] drp_word);
    logic [15:0] w_prod;
    w_prod = {4'b0000, drp_word[15:4]} * 16'd15;
    return w_prod[15:7];
  endfunction

endpackage

// File: rtl/capture_bank_ram.sv
// Ping-pong trace store: two banks of 2**IW x 9 bits, bank chosen by the address MSB.
// Synchronous write, registered read, single clock.
module capture_bank_ram #(
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW:0]   i_waddr,
  input  logic [8:0]    i_wdata,
  input  logic [IW:0]   i_raddr,
  output logic [8:0]    o_rdata
);

  logic [8:0] r_mem [0:(2**(IW+1))-1];
  logic [8:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// XADC DRP sampler: reads one result per tick, scales it and fills a ping-pong trace
// buffer that swaps only on frame_start. Optional rising-edge trigger: ADC_TRIGGER_EN.
module adc_capture_ctrl
  import voltmeter_pkg::*;
#(
  parameter int         DEPTH      = SCREEN_W,
  parameter int         SAMPLE_DIV = 1000,
  parameter logic [6:0] CHAN_ADDR  = XADC_VAUX6_ADDR,
  parameter int         DRP_TMO    = 63
) (
  input  logic        clk,
  input  logic        rst,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  input  logic        frame_start,
  input  logic [8:0]  trig_level,
  input  logic [9:0]  rd_x,
  output logic [8:0]  rd_height,
  output logic        rd_valid,
  output logic        drp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(DRP_TMO + 1);
  localparam logic [10:0] DEPTH_X = 11'(DEPTH);

  ctrl_state_e   r_state;
  logic [CW-1:0] r_tick_cnt;
  logic [TW-1:0] r_tmo;
  logic [IW-1:0] r_ptr;
  logic          r_bank;
  logic [8:0]    r_height;
  logic          r_den;
  logic          r_rd_valid;
  logic          r_err;
  logic          r_rd_mask;
  logic          w_tick;
  logic [8:0]    w_ram_q;

`ifdef ADC_TRIGGER_EN
  localparam int DW = $clog2(2 * DEPTH + 1);
  logic [8:0]    r_prev_height;
  logic [DW-1:0] r_disc_cnt;
`else
  logic w_unused_trig;
  assign w_unused_trig = ^trig_level;
`endif

  assign w_tick = (r_tick_cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tmo      <= '0;
      r_ptr      <= '0;
      r_bank     <= 1'b0;
      r_height   <= '0;
      r_den      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
`ifdef ADC_TRIGGER_EN
      r_prev_height <= '0;
      r_disc_cnt    <= '0;
`endif
    end else begin
      r_den <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_WAIT_TICK;
        ST_WAIT_TICK: begin
          if (w_tick) begin
            r_state <= ST_DRP_REQ;
            r_den   <= 1'b1;
          end
        end
        ST_DRP_REQ: begin
          r_state <= ST_DRP_WAIT;
          r_tmo   <= '0;
        end
        ST_DRP_WAIT: begin
          if (drp_drdy) begin
            r_height <= scale_height(drp_do);
`ifdef ADC_TRIGGER_EN
            r_state  <= (r_ptr == '0) ? ST_ARM : ST_STORE;
`else
            r_state  <= ST_STORE;
`endif
          end else if (r_tmo == TW'(DRP_TMO - 1)) begin
            // Sample is lost; retry on the next tick without touching wr_ptr.
            r_err   <= 1'b1;
            r_state <= ST_WAIT_TICK;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_STORE: begin
          if (r_ptr == IW'(DEPTH - 1)) begin
            r_state <= ST_FULL;
          end else begin
            r_ptr   <= r_ptr + IW'(1);
            r_state <= ST_WAIT_TICK;
          end
        end
        ST_FULL: begin
          if (frame_start) begin
            r_bank     <= ~r_bank;
            r_ptr      <= '0;
            r_rd_valid <= 1'b1;
            r_state    <= ST_WAIT_TICK;
          end
        end
`ifdef ADC_TRIGGER_EN
        ST_ARM: begin
          r_prev_height <= r_height;
          if (((r_prev_height < trig_level) && (trig_level <= r_height)) ||
              (r_disc_cnt == DW'(2 * DEPTH))) begin
            r_disc_cnt <= '0;
            r_state    <= ST_STORE;
          end else begin
            r_disc_cnt <= r_disc_cnt + DW'(1);
            r_state    <= ST_WAIT_TICK;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM output is not reset, so a registered mask provides the 0 for invalid reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_mask <= 1'b1;
    end else begin
      r_rd_mask <= !r_rd_valid || ({1'b0, rd_x} >= DEPTH_X);
    end
  end

  capture_bank_ram #(
    .IW (IW)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_state == ST_STORE),
    .i_waddr ({r_bank, r_ptr}),
    .i_wdata (r_height),
    .i_raddr ({~r_bank, rd_x[IW-1:0]}),
    .o_rdata (w_ram_q)
  );

  assign drp_den   = r_den;
  assign drp_daddr = CHAN_ADDR;
  assign rd_height = r_rd_mask ? 9'd0 : w_ram_q;
  assign rd_valid  = r_rd_valid;
  assign drp_err   = r_err;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl with a small DEPTH and a DRP responder model.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 8;
  localparam int SDIV  = 100;
  localparam int TMO   = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'h0000;
  logic        frame_start = 1'b0;
  logic [8:0]  trig_level = 9'd0;
  logic [9:0]  rd_x = 10'd0;
  logic [8:0]  rd_height;
  logic        rd_valid;
  logic        drp_err;

  adc_capture_ctrl #(
    .DEPTH      (DEPTH),
    .SAMPLE_DIV (SDIV),
    .CHAN_ADDR  (7'h16),
    .DRP_TMO    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .drp_den     (drp_den),
    .drp_daddr   (drp_daddr),
    .drp_drdy    (drp_drdy),
    .drp_do      (drp_do),
    .frame_start (frame_start),
    .trig_level  (trig_level),
    .rd_x        (rd_x),
    .rd_height   (rd_height),
    .rd_valid    (rd_valid),
    .drp_err     (drp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- read scoreboard ----------------
  int   exp_q[$];
  int   x_q[$];
  logic rd_req = 1'b0;
  logic req_d  = 1'b0;
  always @(posedge clk) req_d <= rd_req;

  initial begin
    int e;
    int x;
    forever begin
      @(negedge clk);
      if (req_d) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_scoreboard: output with no expected entry, got %0d", rd_height);
        end else begin
          e = exp_q.pop_front();
          x = x_q.pop_front();
          check($sformatf("rd_height[x=%0d]", x), rd_height, e);
        end
      end
    end
  end

  task automatic rd(input int x, input int e);
    @(posedge clk);
    #1;
    rd_x   = 10'(x);
    rd_req = 1'b1;
    exp_q.push_back(e);
    x_q.push_back(x);
  endtask

  task automatic rd_end();
    @(posedge clk);
    #1 rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- DRP responder + den monitor ----------------
  logic        drop_next = 1'b0;
  logic [15:0] resp_data = 16'hFFF0;
  logic [15:0] data_q[$];
  int          den_cnt = 0;
  int          last_den_cyc = 0;
  int          last_period = 0;

  initial begin
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (drp_den === 1'b1) begin
        if (drop_next) begin
          drop_next = 1'b0;
        end else begin
          d = (data_q.size() > 0) ? data_q.pop_front() : resp_data;
          repeat (3) @(posedge clk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = d;
          @(posedge clk);
          #1 drp_drdy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (drp_den === 1'b1) begin
        den_cnt++;
        last_period  = cyc - last_den_cyc;
        last_den_cyc = cyc;
      end
    end
  end

  task automatic wait_dens(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (den_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, den_cnt, target);
  endtask

  task automatic pulse_fs();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_drp_den", drp_den, 0);
    check("rst_drp_daddr", drp_daddr, 7'h16);
    check("rst_rd_height", rd_height, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_drp_err", drp_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef ADC_TRIGGER_EN
    // Ramp from code 1280 in steps of 64: 12 discards, crossing at code 2048.
    trig_level = 9'd240;
    for (int i = 0; i < 20; i++) data_q.push_back(16'((1280 + 64 * i) << 4));
    wait_dens(20, 20 * SDIV + 50, "t6_dens");
    repeat (20) @(posedge clk);
    pulse_fs();
    @(negedge clk);
    check("t6_rd_valid", rd_valid, 1);
    rd(0, 240);
    rd(1, 247);
    rd(7, 292);
    rd_end();
`else
    // Test 1: full-scale data, den period, FULL holds.
    for (int i = 1; i <= DEPTH; i++) begin
      wait_dens(i, SDIV + 20, "t1_den");
      if (i > 1) check("t1_den_period", last_period, SDIV);
    end
    repeat (20) @(posedge clk);
    base = den_cnt;
    repeat (3 * SDIV) @(posedge clk);
    check("t1_full_holds", den_cnt, base);
    check("t1_rd_valid_before_swap", rd_valid, 0);
    rd(0, 0);
    rd_end();

    // Test 2: swap, read back full trace and out-of-range columns.
    drop_next = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin
      data_q.push_back(16'h8000);
      data_q.push_back(16'h0000);
    end
    pulse_fs();
    @(negedge clk);
    check("t2_rd_valid", rd_valid, 1);
    for (int i = 0; i < DEPTH; i++) rd(i, 479);
    rd(DEPTH, 0);
    rd(700, 0);
    rd_end();

    // Test 3: dropped request times out after DRP_TMO cycles.
    wait_dens(base + 1, 2 * SDIV, "t3_den");
    check("t3_err_before", drp_err, 0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t3_err_not_yet", drp_err, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t3_err_set", drp_err, 1);
    wait_dens(base + 2, 2 * SDIV, "t3_reissue");
    check("t3_reissue_period", last_period, SDIV);

    // Test 4: frame_start mid-capture must not swap.
    wait_dens(base + 4, 3 * SDIV, "t4_den3");
    pulse_fs();
    rd(0, 479);
    rd(1, 479);
    rd_end();
    wait_dens(base + 9, 6 * SDIV, "t4_den8");
    repeat (20) @(posedge clk);
    rd(0, 479);
    rd_end();
    pulse_fs();
    for (int i = 0; i < DEPTH; i++) rd(i, (i % 2 == 0) ? 240 : 0);
    rd_end();
    check("t4_err_sticky", drp_err, 1);

    // Test 5: reset during DRP_WAIT, late drdy after release.
    base = den_cnt;
    wait_dens(base + 1, 2 * SDIV, "t5_den");
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_drp_den", drp_den, 0);
    check("t5_rst_rd_valid", rd_valid, 0);
    check("t5_rst_drp_err", drp_err, 0);
    check("t5_rst_rd_height", rd_height, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_err_after", drp_err, 0);
    check("t5_valid_after", rd_valid, 0);
    rd(0, 0);
    rd_end();
    wait_dens(base + 2, SDIV + 20, "t5_resume");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
